dpi_pattern_gen: RTL and testbench

//  Pixel-colour stage between the VGA/DPI timing generator and the parallel-RGB GPIO pins.

---
 rtl/dpi_pattern_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_dpi_pattern_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_pattern_gen.sv
// dpi_pattern_gen: RGB888 test-pattern stage between the DPI timing
// generator and the parallel-RGB pins. Two register stages keep the
// syncs, blank and colour aligned. The pattern changes only on a vsync
// rising edge: either by automatic stepping or by loading sel.
module dpi_pattern_gen #(
    parameter int H_ACTIVE           = 640,
    parameter int V_ACTIVE           = 480,
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int CHECK_SHIFT        = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       auto_cycle,
    input  logic [1:0] sel,
    input  logic       in_hsync,
    input  logic       in_vsync,
    input  logic       in_blank,
    input  logic [9:0] in_x,
    input  logic [9:0] in_y,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic       out_blank,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [1:0] pattern,
    output logic       frame_tick
);

    // Bar width is fixed at elaboration; x beyond 8 bars clamps to the last bar.
    localparam int BAR_W = H_ACTIVE / 8;

    // A one-frame cycle still needs a 1-bit counter, which then always sits at its wrap value.
    localparam int CNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_CHECKER  = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_FRAMED   = 2'd3
    } pattern_e;

    // Frame and pattern control
    logic             prev_vsync_q, prev_vsync_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    pattern_e         pattern_q, pattern_d;
    logic             frame_tick_q, frame_tick_d;
    logic             vsync_rise;
    logic             cnt_wrap;

    // Stage 1: delayed timing plus pre-decoded pattern terms
    logic             s1_hsync_q, s1_hsync_d;
    logic             s1_vsync_q, s1_vsync_d;
    logic             s1_blank_q, s1_blank_d;
    logic [9:0]       s1_x_q, s1_x_d;
    logic [9:0]       s1_y_q, s1_y_d;
    logic [2:0]       s1_bar_q, s1_bar_d;
    logic             s1_check_q, s1_check_d;
    pattern_e         s1_pattern_q, s1_pattern_d;

    // Stage 2: final timing and colour
    logic             s2_hsync_q, s2_hsync_d;
    logic             s2_vsync_q, s2_vsync_d;
    logic             s2_blank_q, s2_blank_d;
    logic [23:0]      s2_rgb_q, s2_rgb_d;

    // Checkerboard cell coordinates; only their low bits matter
    logic [9:0]       x_cell;
    logic [9:0]       y_cell;
    logic [2:0]       bar_idx;

    assign x_cell = in_x >> CHECK_SHIFT;
    assign y_cell = in_y >> CHECK_SHIFT;

    // Standard colour-bar sequence, brightest first, ending in black.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Vsync edge detection, frame counting and pattern selection.
    always_comb begin
        vsync_rise   = in_vsync & ~prev_vsync_q;
        cnt_wrap     = (frame_cnt_q == CNT_LAST);
        prev_vsync_d = in_vsync;
        frame_tick_d = vsync_rise;
        frame_cnt_d  = frame_cnt_q;
        pattern_d    = pattern_q;
        if (vsync_rise) begin
            frame_cnt_d = cnt_wrap ? '0 : frame_cnt_q + CNT_W'(1);
            if (auto_cycle) begin
                if (cnt_wrap) begin
                    pattern_d = pattern_e'(pattern_q + 2'd1);
                end
            end else begin
                pattern_d = pattern_e'(sel);
            end
        end
    end

    // Bar index is the highest bar whose left boundary x has reached.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(in_x) >= k * BAR_W) begin
                bar_idx = 3'(k);
            end
        end
    end

    // Stage 1 next state: capture timing and pre-decode bar and checker terms.
    always_comb begin
        s1_hsync_d   = in_hsync;
        s1_vsync_d   = in_vsync;
        s1_blank_d   = in_blank;
        s1_x_d       = in_x;
        s1_y_d       = in_y;
        s1_bar_d     = bar_idx;
        s1_check_d   = x_cell[0] ^ y_cell[0];
        s1_pattern_d = pattern_q;
    end

    // Stage 2 next state: colour from the stage-1 pattern, forced black while blanked.
    always_comb begin
        s2_hsync_d = s1_hsync_q;
        s2_vsync_d = s1_vsync_q;
        s2_blank_d = s1_blank_q;
        s2_rgb_d   = 24'h000000;
        case (s1_pattern_q)
            PAT_BARS:     s2_rgb_d = bar_colour(s1_bar_q);
            PAT_CHECKER:  s2_rgb_d = s1_check_q ? 24'h000000 : 24'hFFFFFF;
            PAT_GRADIENT: s2_rgb_d = {s1_x_q[9:2], s1_y_q[8:1], 8'h80};
            PAT_FRAMED: begin
                if ((s1_x_q == 10'd0) || (s1_x_q == X_LAST) ||
                    (s1_y_q == 10'd0) || (s1_y_q == Y_LAST)) begin
                    s2_rgb_d = 24'hFF0000;
                end else begin
                    s2_rgb_d = 24'hFFFFFF;
                end
            end
            default:      s2_rgb_d = 24'h000000;
        endcase
        if (s1_blank_q) begin
            s2_rgb_d = 24'h000000;
        end
    end

    // Control registers; prev_vsync resets high so a vsync held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_vsync_q <= 1'b1;
            frame_cnt_q  <= '0;
            pattern_q    <= PAT_BARS;
            frame_tick_q <= 1'b0;
        end else begin
            prev_vsync_q <= prev_vsync_d;
            frame_cnt_q  <= frame_cnt_d;
            pattern_q    <= pattern_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Stage 1 registers; reset to a blanked, idle pixel.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_hsync_q   <= 1'b0;
            s1_vsync_q   <= 1'b0;
            s1_blank_q   <= 1'b1;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_bar_q     <= '0;
            s1_check_q   <= 1'b0;
            s1_pattern_q <= PAT_BARS;
        end else begin
            s1_hsync_q   <= s1_hsync_d;
            s1_vsync_q   <= s1_vsync_d;
            s1_blank_q   <= s1_blank_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_bar_q     <= s1_bar_d;
            s1_check_q   <= s1_check_d;
            s1_pattern_q <= s1_pattern_d;
        end
    end

    // Stage 2 registers drive the pins directly.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s2_hsync_q <= 1'b0;
            s2_vsync_q <= 1'b0;
            s2_blank_q <= 1'b1;
            s2_rgb_q   <= 24'h000000;
        end else begin
            s2_hsync_q <= s2_hsync_d;
            s2_vsync_q <= s2_vsync_d;
            s2_blank_q <= s2_blank_d;
            s2_rgb_q   <= s2_rgb_d;
        end
    end

    assign out_hsync  = s2_hsync_q;
    assign out_vsync  = s2_vsync_q;
    assign out_blank  = s2_blank_q;
    assign red        = s2_rgb_q[23:16];
    assign green      = s2_rgb_q[15:8];
    assign blue       = s2_rgb_q[7:0];
    assign pattern    = pattern_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_dpi_pattern_gen.sv
// Testbench for dpi_pattern_gen: directed checks with literal expectations
// followed by randomized stimulus compared every cycle against a
// behavioural model of the pixel pipeline and frame/pattern rules.
module tb_dpi_pattern_gen;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int FPP      = 4;
    localparam int CS       = 5;

    logic       clk = 1'b0;
    logic       resetn;
    logic       auto_cycle;
    logic [1:0] sel;
    logic       in_hsync, in_vsync, in_blank;
    logic [9:0] in_x, in_y;
    logic       out_hsync, out_vsync, out_blank;
    logic [7:0] red, green, blue;
    logic [1:0] pattern;
    logic       frame_tick;

    int compared   = 0;
    int mismatched = 0;
    int tick_count = 0;

    dpi_pattern_gen #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .FRAMES_PER_PATTERN(FPP),
        .CHECK_SHIFT(CS)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .auto_cycle(auto_cycle),
        .sel(sel),
        .in_hsync(in_hsync),
        .in_vsync(in_vsync),
        .in_blank(in_blank),
        .in_x(in_x),
        .in_y(in_y),
        .out_hsync(out_hsync),
        .out_vsync(out_vsync),
        .out_blank(out_blank),
        .red(red),
        .green(green),
        .blue(blue),
        .pattern(pattern),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // A pixel as it travels down the pipeline, with the pattern it will be drawn in.
    typedef struct {
        logic hs;
        logic vs;
        logic blank;
        int   x;
        int   y;
        int   pat;
    } pix_t;

    pix_t st1, st2;
    int   m_cnt, m_pat;
    logic m_prev, m_tick;
    logic model_ready = 1'b0;

    // Colour a pixel directly from the pattern rules.
    function automatic logic [23:0] model_rgb(input pix_t p);
        int bar;
        if (p.blank) return 24'h000000;
        case (p.pat)
            0: begin
                bar = p.x / (H_ACTIVE / 8);
                if (bar > 7) bar = 7;
                case (bar)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: return ((((p.x >> CS) ^ (p.y >> CS)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            2: return {8'(p.x / 4), 8'((p.y / 2) % 256), 8'h80};
            default: begin
                if (p.x == 0 || p.x == H_ACTIVE - 1 || p.y == 0 || p.y == V_ACTIVE - 1)
                    return 24'hFF0000;
                return 24'hFFFFFF;
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: two-deep pixel queue plus frame/pattern rules.
    always @(posedge clk) begin
        pix_t cur;
        logic rise;
        logic wrap;
        if (!resetn) begin
            m_cnt  = 0;
            m_pat  = 0;
            m_prev = 1'b1;
            m_tick = 1'b0;
            st1    = '{hs: 1'b0, vs: 1'b0, blank: 1'b1, x: 0, y: 0, pat: 0};
            st2    = st1;
            model_ready = 1'b1;
        end else begin
            cur  = '{hs: in_hsync, vs: in_vsync, blank: in_blank, x: int'(in_x), y: int'(in_y), pat: m_pat};
            st2  = st1;
            st1  = cur;
            rise = in_vsync && !m_prev;
            m_prev = in_vsync;
            m_tick = rise;
            if (rise) begin
                wrap  = (m_cnt == FPP - 1);
                m_cnt = wrap ? 0 : m_cnt + 1;
                if (auto_cycle) begin
                    if (wrap) m_pat = (m_pat + 1) % 4;
                end else begin
                    m_pat = int'(sel);
                end
            end
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (model_ready) begin
            checkOutput("out_hsync", 32'(out_hsync), 32'(st2.hs));
            checkOutput("out_vsync", 32'(out_vsync), 32'(st2.vs));
            checkOutput("out_blank", 32'(out_blank), 32'(st2.blank));
            checkOutput("rgb", 32'({red, green, blue}), 32'(model_rgb(st2)));
            checkOutput("pattern", 32'(pattern), 32'(m_pat));
            checkOutput("frame_tick", 32'(frame_tick), 32'(m_tick));
        end
    end

    // One clock of input drive, applied away from the sampling edge.
    task automatic applyStimulus(input logic rst_n, input logic ac, input logic [1:0] s,
                                 input logic hs, input logic vs, input logic bl,
                                 input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        resetn     = rst_n;
        auto_cycle = ac;
        sel        = s;
        in_hsync   = hs;
        in_vsync   = vs;
        in_blank   = bl;
        in_x       = x;
        in_y       = y;
    endtask

    task automatic vsyncEdge(input logic ac, input logic [1:0] s);
        applyStimulus(1'b1, ac, s, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0);
        tick_count += int'(frame_tick);
        applyStimulus(1'b1, ac, s, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        tick_count += int'(frame_tick);
        applyStimulus(1'b1, ac, s, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        tick_count += int'(frame_tick);
    endtask

    // Hold a visible pixel long enough to reach the pins, then check its colour.
    task automatic pixelCheck(input string name, input logic [1:0] s,
                              input logic [9:0] x, input logic [9:0] y, input logic [23:0] exp);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, s, 1'b0, 1'b0, 1'b0, x, y);
        end
        checkOutput(name, 32'({red, green, blue}), 32'(exp));
    endtask

    initial begin
        logic vs_rand;
        logic ac_rand;

        resetn = 1'b0; auto_cycle = 1'b0; sel = 2'd0;
        in_hsync = 1'b0; in_vsync = 1'b0; in_blank = 1'b1; in_x = '0; in_y = '0;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 10'($urandom), 10'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        checkOutput("reset out_blank", 32'(out_blank), 32'd1);
        checkOutput("reset rgb", 32'({red, green, blue}), 32'h0);
        checkOutput("reset pattern", 32'(pattern), 32'd0);
        checkOutput("reset frame_tick", 32'(frame_tick), 32'd0);

        // Latency of a single hsync pulse with blank asserted
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 10'd7, 10'd3);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 10'd7, 10'd3);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 10'd7, 10'd3);
        checkOutput("hsync N+1", 32'(out_hsync), 32'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 10'd7, 10'd3);
        checkOutput("hsync N+2", 32'(out_hsync), 32'd1);
        checkOutput("blank rgb N+2", 32'({red, green, blue}), 32'h0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 10'd7, 10'd3);
        checkOutput("hsync N+3", 32'(out_hsync), 32'd0);

        // Colour bars, including both sides of the last bar boundaries
        vsyncEdge(1'b0, 2'd0);
        pixelCheck("bars x0", 2'd0, 10'd0, 10'd10, 24'hFFFFFF);
        pixelCheck("bars x80", 2'd0, 10'd80, 10'd10, 24'hFFFF00);
        pixelCheck("bars x559", 2'd0, 10'd559, 10'd10, 24'h0000FF);
        pixelCheck("bars x560", 2'd0, 10'd560, 10'd10, 24'h000000);
        pixelCheck("bars x639", 2'd0, 10'd639, 10'd10, 24'h000000);
        pixelCheck("bars x700", 2'd0, 10'd700, 10'd10, 24'h000000);

        // Checkerboard
        vsyncEdge(1'b0, 2'd1);
        checkOutput("pattern sel1", 32'(pattern), 32'd1);
        pixelCheck("check 0,0", 2'd1, 10'd0, 10'd0, 24'hFFFFFF);
        pixelCheck("check 32,0", 2'd1, 10'd32, 10'd0, 24'h000000);
        pixelCheck("check 32,32", 2'd1, 10'd32, 10'd32, 24'hFFFFFF);
        pixelCheck("check 31,31", 2'd1, 10'd31, 10'd31, 24'hFFFFFF);

        // Gradient
        vsyncEdge(1'b0, 2'd2);
        pixelCheck("grad 200,100", 2'd2, 10'd200, 10'd100, 24'h323280);

        // Framed white
        vsyncEdge(1'b0, 2'd3);
        checkOutput("pattern sel3", 32'(pattern), 32'd3);
        pixelCheck("frame 0,5", 2'd3, 10'd0, 10'd5, 24'hFF0000);
        pixelCheck("frame 5,5", 2'd3, 10'd5, 10'd5, 24'hFFFFFF);
        pixelCheck("frame 5,479", 2'd3, 10'd5, 10'd479, 24'hFF0000);
        pixelCheck("frame 639,5", 2'd3, 10'd639, 10'd5, 24'hFF0000);

        // Automatic stepping every FPP frames
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        tick_count = 0;
        for (int e = 1; e <= 16; e++) begin
            vsyncEdge(1'b1, 2'd0);
            if (e == 3)  checkOutput("auto after 3", 32'(pattern), 32'd0);
            if (e == 4)  checkOutput("auto after 4", 32'(pattern), 32'd1);
            if (e == 8)  checkOutput("auto after 8", 32'(pattern), 32'd2);
            if (e == 16) checkOutput("auto after 16", 32'(pattern), 32'd0);
        end
        checkOutput("tick count", 32'(tick_count), 32'd16);

        // Reset mid-frame with vsync held high through release
        for (int e = 0; e < 11; e++) vsyncEdge(1'b1, 2'd0);
        checkOutput("pattern before reset", 32'(pattern), 32'd2);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0);
        tick_count = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0);
            tick_count += int'(frame_tick);
        end
        checkOutput("no tick after reset", 32'(tick_count), 32'd0);
        checkOutput("pattern after reset", 32'(pattern), 32'd0);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        tick_count = 0;
        for (int e = 1; e <= 4; e++) begin
            vsyncEdge(1'b1, 2'd0);
            if (e == 3) checkOutput("counter cleared 3", 32'(pattern), 32'd0);
            if (e == 4) checkOutput("counter cleared 4", 32'(pattern), 32'd1);
        end
        checkOutput("ticks after release", 32'(tick_count), 32'd4);

        // Randomized traffic checked by the model every cycle
        vs_rand = 1'b0;
        ac_rand = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) vs_rand = ~vs_rand;
            if ($urandom_range(0, 199) == 0) ac_rand = ~ac_rand;
            applyStimulus(($urandom_range(0, 299) != 0), ac_rand, 2'($urandom), 1'($urandom),
                          vs_rand, ($urandom_range(0, 3) == 0), 10'($urandom), 10'($urandom));
        end
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
